// File: rtl/morse_stream_decoder.sv
// morse_stream_decoder: on/off keying to ASCII token stream with an output FIFO.
// Optional MORSE_DEBOUNCE_EN adds a stability filter after the input synchroniser.
module morse_stream_decoder #(
    parameter int UNIT_CYCLES     = 66,
    parameter int MAX_SYMBOLS     = 6,
    parameter int FIFO_DEPTH      = 4,
    parameter int CNT_WIDTH       = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       signal,
    input  logic       ready,
    output logic [7:0] letter,
    output logic       done,
    output logic       error,
    output logic       overflow
);
    localparam int LW = $clog2(MAX_SYMBOLS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] DAH = CNT_WIDTH'(2 * UNIT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] SPC = CNT_WIDTH'(5 * UNIT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] SAT = CNT_WIDTH'(7 * UNIT_CYCLES);
    // ITU tables indexed by pattern value; first character sits at pattern 0
    localparam logic [15:0]  L1 = "ET";
    localparam logic [31:0]  L2 = "IANM";
    localparam logic [63:0]  L3 = "SURWDKGO";
    localparam logic [127:0] L4 = "HVF?L?PJBXCYZQ??";
    localparam logic [255:0] L5 = "54?3???2???????16???????7???8?90";

    if (UNIT_CYCLES < 4 || MAX_SYMBOLS < 5 || FIFO_DEPTH < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
        $error("morse_stream_decoder: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, MARK, GAP} state_t;

    state_t                state, state_n;
    logic                  s_meta, s_sync, s_in, s_prev, rise, fall;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [LW-1:0]         len, len_n;
    logic [4:0]            pattern, pattern_n;
    logic                  ovf_pat, ovf_n, space_armed, armed_n;
    logic                  push, push_bad;
    logic [7:0]            push_data, code, last;
    logic [AW:0]           wp, rp;
    logic [7:0]            mem [FIFO_DEPTH];
    logic                  empty, full, pop, wr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_meta <= 1'b0;
            s_sync <= 1'b0;
            s_prev <= 1'b0;
        end else begin
            s_meta <= signal;
            s_sync <= s_meta;
            s_prev <= s_in;
        end
    end

`ifdef MORSE_DEBOUNCE_EN
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DBW-1:0] db_cnt;
    logic           filt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt <= '0;
            filt   <= 1'b0;
        end else if (s_sync == filt) begin
            db_cnt <= '0;
        end else if (db_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt <= '0;
            filt   <= s_sync;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end
    assign s_in = filt;
`else
    assign s_in = s_sync;
`endif

    assign rise = s_in & ~s_prev;
    assign fall = ~s_in & s_prev;

    assign code = len == LW'(1) ? L1[8*(1 - int'(pattern[0])) +: 8]
                : len == LW'(2) ? L2[8*(3 - int'(pattern[1:0])) +: 8]
                : len == LW'(3) ? L3[8*(7 - int'(pattern[2:0])) +: 8]
                : len == LW'(4) ? L4[8*(15 - int'(pattern[3:0])) +: 8]
                : len == LW'(5) ? L5[8*(31 - int'(pattern[4:0])) +: 8]
                : 8'h3F;

    always_comb begin
        state_n   = state;
        len_n     = len;
        pattern_n = pattern;
        ovf_n     = ovf_pat;
        armed_n   = space_armed;
        push      = 1'b0;
        push_bad  = 1'b0;
        push_data = 8'h20;
        case (state)
            IDLE: state_n = rise ? MARK : IDLE;
            MARK: begin
                if (fall) begin
                    state_n = GAP;
                    if (len == LW'(MAX_SYMBOLS)) begin
                        ovf_n = 1'b1;
                    end else begin
                        len_n     = len + 1'b1;
                        pattern_n = {pattern[3:0], cnt >= DAH};
                    end
                end
            end
            GAP: begin
                if (cnt == DAH && len != '0) begin
                    push      = 1'b1;
                    push_bad  = ovf_pat || code == 8'h3F;
                    push_data = push_bad ? 8'h3F : code;
                    len_n     = '0;
                    pattern_n = '0;
                    ovf_n     = 1'b0;
                    armed_n   = 1'b1;
                end else if (cnt == SPC && space_armed) begin
                    push    = 1'b1;
                    armed_n = 1'b0;
                    state_n = IDLE;
                end
                if (rise) state_n = MARK;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            len         <= '0;
            pattern     <= '0;
            ovf_pat     <= 1'b0;
            space_armed <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= (rise | fall) ? CNT_WIDTH'(1) : (cnt == SAT ? cnt : cnt + 1'b1);
            len         <= len_n;
            pattern     <= pattern_n;
            ovf_pat     <= ovf_n;
            space_armed <= armed_n;
        end
    end

    assign empty  = wp == rp;
    assign full   = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign done   = ~empty;
    assign pop    = done & ready;
    assign wr     = push & (~full | pop);
    assign letter = empty ? last : mem[rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr) mem[wp[AW-1:0]] <= push_data;
    end

    // last keeps the previously presented head so letter holds once the FIFO drains
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp       <= '0;
            rp       <= '0;
            last     <= 8'h00;
            error    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            last     <= letter;
            error    <= push & push_bad;
            overflow <= overflow | (push & full & ~pop);
        end
    end
endmodule

// File: doc/morse_stream_decoder.md
Name: morse_stream_decoder

Overview:
Parametrised successor to the single-letter Morse decoder. Turns a raw on/off keying input into a stream of 8-bit ASCII tokens covering A-Z, 0-9 and word-space. Mark and gap lengths are measured against a configurable unit length. Decoded tokens are buffered in an output FIFO with a valid/ready handshake, so a downstream consumer (UART/display) can stall without losing letters.

Parameters:
UNIT_CYCLES, 66, clk cycles per Morse time unit (>=4)
MAX_SYMBOLS, 6, max dits/dahs buffered per letter (>=5)
FIFO_DEPTH, 4, output token FIFO entries (power of 2, >=2)
CNT_WIDTH, 16, gap/mark counter width (must hold 7*UNIT_CYCLES)
DEBOUNCE_CYCLES, 4, stability window, used only with MORSE_DEBOUNCE_EN

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
signal  input  1  raw keying input, asynchronous to clk; 1 = mark
ready  input  1  consumer accepts head token this cycle
letter  output  8  ASCII token at FIFO head
done  output  1  letter valid (FIFO non-empty)
error  output  1  one-cycle pulse when an undecodable pattern is pushed as '?'
overflow  output  1  sticky; a token was dropped because the FIFO was full

Behaviour:
- Reset (async, active-high): FIFO empty, letter=8'h00, done=0, error=0, overflow=0, FSM=IDLE, symbol count=0, counter=0, sync flops=0, space_armed=0.
- Input path: 2-flop synchroniser, so s_sync lags signal by 2 cycles. Edges are detected on s_sync.
- Counter: increments every cycle, saturates at 7*UNIT_CYCLES, clears to 1 on every s_sync edge.
- FSM states:
  - IDLE: rising edge -> MARK.
  - MARK: falling edge -> classify, then GAP. Length < 2*UNIT_CYCLES is a dit (0); otherwise a dah (1).
    - Shift the bit into pattern LSB-first-in and increment len.
    - If len is already MAX_SYMBOLS, set ovf_pat instead.
  - GAP:
    - Rising edge with counter < 2*UNIT_CYCLES -> MARK (intra-letter).
    - Counter reaching exactly 2*UNIT_CYCLES -> push letter, clear len/pattern/ovf_pat, set space_armed.
    - Counter reaching exactly 5*UNIT_CYCLES with space_armed -> push 8'h20, clear space_armed, -> IDLE.
    - Rising edge after the letter push -> MARK.
- Lookup is on (len, pattern), standard ITU table, len 1-5. Letters are uppercase ASCII 0x41-0x5A; digits 0x30-0x39.
- Unmapped pattern, len 6, or ovf_pat set -> push 8'h3F ('?') and pulse error in the push cycle.
- Latency: letter appears on done 3 cycles after the 2*UNIT gap threshold on the raw input (2 sync + 1 push register).
- FIFO:
  - Push and pop may occur in the same cycle, including when full; in that case the push is accepted.
  - Push when full without a pop -> token dropped, overflow set until reset.
  - Pop when done && ready. letter holds the head and is stable while done && !ready.
  - Empty FIFO -> done=0 and letter holds its last value.
- No leading space after reset or after IDLE. At most one space per gap run.
- Reset mid-mark or mid-gap: everything cleared; a partial letter is discarded and never emitted.

Optional Feature:
MORSE_DEBOUNCE_EN
- Defined: s_sync feeds a filter whose output changes only after the new level has been stable for DEBOUNCE_CYCLES consecutive cycles. Shorter glitches are ignored entirely, with no edge and no counter clear. All latencies grow by DEBOUNCE_CYCLES.
- Undefined: no filter; s_sync drives the edge detector directly, and any 1-cycle pulse counts as a dit.

Test Plan:
- Defaults, ready=1; key 1u mark, 1u gap, 3u mark, 3u gap, 1u mark, 7u gap (u=66 cycles) -> tokens 0x41 'A', 0x45 'E', 0x20, each done for 1 cycle; error=0, overflow=0.
- Key "...---..." with 3u gaps between letters, then 7u gap -> 0x53, 0x4F, 0x53, 0x20.
- Key 6 dits then a 3u gap -> 0x3F with a 1-cycle error pulse. Key 7 dits (ovf_pat) -> 0x3F and error.
- ready=0; key 5 letters 'E' separated by 3u gaps -> done=1, letter=0x45 stable; 4 tokens held, overflow=1 after the 5th push; raise ready -> exactly 4 pops, done falls.
- Assert reset for 1 cycle mid-dah, then key 'T' -> only 0x54 emitted; all outputs at reset values during reset.
- With MORSE_DEBOUNCE_EN and DEBOUNCE_CYCLES=4: a 2-cycle high glitch inside a 3u gap -> no extra symbol; letter decoded unchanged. Without the macro, the same stimulus -> extra dit/'?' per table.
